// File: rtl/mc_pkg.sv
// Shared definitions for the banked memory controller: controller FSM
// states and default parameter values.
package mc_pkg;

  localparam int unsigned DEF_DATA_W     = 256;
  localparam int unsigned DEF_ADDR_W     = 6;
  localparam int unsigned DEF_NUM_BANKS  = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } mc_state_e;

endpackage

// File: rtl/mc_req_fifo.sv
// In-order request queue with first-word fall-through head.
// Ports: clk, rst (sync, active-high); push/wdata enqueue; pop dequeues;
// head_c is the current head entry; full, empty and count reflect occupancy.
module mc_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full queue never accepts, even when a pop frees a slot this cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = store[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/banked_memory_controller.sv
// Queues read/write requests and issues them one at a time to a set of
// synchronous memory banks selected by the top address bits.
// Ports: clk, rst (sync, active-high); req_* request channel with ready;
// rsp_valid/rsp_rdata read response strobe; mem_* shared bank interface,
// mem_rdata flattened with bank b at [b*DATA_W +: DATA_W].
module banked_memory_controller
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [NUM_BANKS-1:0]          mem_en,
  output logic [NUM_BANKS-1:0]          mem_we,
  output logic [ADDR_W-$clog2(NUM_BANKS)-1:0] mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int unsigned BANK_AW    = ADDR_W - BANK_SEL_W;
  localparam int unsigned REQ_W      = 1 + ADDR_W + DATA_W;
  localparam int unsigned LAT_W      = $clog2(RD_LATENCY + 1);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  mc_state_e              state;
  logic                   iss_write;
  logic [ADDR_W-1:0]      iss_addr;
  logic [DATA_W-1:0]      iss_wdata;
  logic [LAT_W-1:0]       lat_cnt;

  logic [REQ_W-1:0]       head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   push;
  logic                   pop;

  logic                   head_write;
  logic [ADDR_W-1:0]      head_addr;
  logic [BANK_SEL_W-1:0]  head_sel;
  logic [BANK_SEL_W-1:0]  iss_sel;
  logic [NUM_BANKS-1:0]   head_onehot;
  logic [DATA_W-1:0]      sel_rdata;
  logic                   unused_count;

  assign req_ready    = !fifo_full;
  assign push         = req_valid && !fifo_full;
  assign pop          = (state == IDLE) && !fifo_empty;
  assign unused_count = ^fifo_count;

  mc_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wdata  ({req_write, req_addr, req_wdata}),
    .pop    (pop),
    .head_c (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head_write  = head[REQ_W-1];
  assign head_addr   = head[DATA_W +: ADDR_W];
  assign head_sel    = head_addr[ADDR_W-1 -: BANK_SEL_W];
  assign head_onehot = NUM_BANKS'(1) << head_sel;
  assign iss_sel     = iss_addr[ADDR_W-1 -: BANK_SEL_W];

  // Bank address and write data are shared and simply follow the issue register.
  assign mem_addr  = iss_addr[BANK_AW-1:0];
  assign mem_wdata = iss_wdata;

  // Read-data mux for the bank of the request in flight.
  always_comb begin
    sel_rdata = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (iss_sel == BANK_SEL_W'(b)) sel_rdata = mem_rdata[b*DATA_W +: DATA_W];
    end
  end

  // Controller FSM; bank strobes are set on entry to ISSUE so they are
  // high for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      iss_write <= 1'b0;
      iss_addr  <= '0;
      iss_wdata <= '0;
      lat_cnt   <= '0;
      mem_en    <= '0;
      mem_we    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_en    <= '0;
      mem_we    <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            iss_write <= head_write;
            iss_addr  <= head_addr;
            iss_wdata <= head[DATA_W-1:0];
            mem_en    <= head_onehot;
            mem_we    <= head_write ? head_onehot : '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= '0;
          state   <= iss_write ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
            rsp_rdata <= sel_rdata;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_memory_controller.sv
// Directed bench for banked_memory_controller: default instance (2 banks,
// latency 1) plus a 4-bank, latency-3 instance for the wide-bank read.
module tb_banked_memory_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic         req_valid_a, req_ready_a, req_write_a;
  logic [5:0]   req_addr_a;
  logic [255:0] req_wdata_a;
  logic         rsp_valid_a;
  logic [255:0] rsp_rdata_a;
  logic [1:0]   mem_en_a, mem_we_a;
  logic [4:0]   mem_addr_a;
  logic [255:0] mem_wdata_a;
  logic [511:0] mem_rdata_a;
  assign mem_rdata_a = {256'hDEAD, 256'h1111};

  banked_memory_controller dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  // Four banks, read latency 3
  logic          req_valid_b, req_ready_b, req_write_b;
  logic [5:0]    req_addr_b;
  logic [255:0]  req_wdata_b;
  logic          rsp_valid_b;
  logic [255:0]  rsp_rdata_b;
  logic [3:0]    mem_en_b, mem_we_b;
  logic [3:0]    mem_addr_b;
  logic [255:0]  mem_wdata_b;
  logic [1023:0] mem_rdata_b;
  assign mem_rdata_b = {256'hB3B3, 256'hB2B2, 256'hB1B1, 256'hB0B0};

  banked_memory_controller #(.NUM_BANKS(4), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;
  logic [4:0]   iss_addr_q [$];
  logic [255:0] iss_data_q [$];
  logic [1:0]   iss_we_q   [$];
  int           iss_cyc_q  [$];
  logic         saw_not_ready;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every issue cycle and response strobe of the default instance.
  always @(negedge clk) begin
    if (!rst && mem_en_a != 2'b00) begin
      iss_addr_q.push_back(mem_addr_a);
      iss_data_q.push_back(mem_wdata_a);
      iss_we_q.push_back(mem_we_a);
      iss_cyc_q.push_back(cyc);
    end
    if (rsp_valid_a) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a request on the default instance and hold it until accepted.
  task automatic send_a(input logic w, input logic [5:0] a, input logic [255:0] d);
    int n;
    req_write_a = w;
    req_addr_a  = a;
    req_wdata_a = d;
    req_valid_a = 1'b1;
    n = 0;
    while (!req_ready_a && n < 50) begin
      saw_not_ready = 1'b1;
      tick();
      n++;
    end
    if (n >= 50) check("accept_timeout", 256'(n), 256'(0));
    tick();
  endtask

  initial begin
    int base_iss;
    int base_rsp;
    int n;
    rst = 1'b1;
    req_valid_a = 0; req_write_a = 0; req_addr_a = '0; req_wdata_a = '0;
    req_valid_b = 0; req_write_b = 0; req_addr_b = '0; req_wdata_b = '0;
    saw_not_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready",     256'(req_ready_a), 256'(1));
    check("rst_rsp_valid", 256'(rsp_valid_a), 256'(0));
    check("rst_rsp_rdata", rsp_rdata_a,       256'(0));
    check("rst_mem_en",    256'(mem_en_a),    256'(0));
    check("rst_mem_we",    256'(mem_we_a),    256'(0));
    check("rst_mem_addr",  256'(mem_addr_a),  256'(0));
    check("rst_mem_wdata", mem_wdata_a,       256'(0));

    // Write 0x05 <- 0xA5: ISSUE in the second cycle after acceptance
    send_a(1'b1, 6'h05, 256'hA5);
    req_valid_a = 1'b0;
    check("wr_idle_en",    256'(mem_en_a),    256'(0));
    tick();
    check("wr_mem_en",     256'(mem_en_a),    256'(2'b01));
    check("wr_mem_we",     256'(mem_we_a),    256'(2'b01));
    check("wr_mem_addr",   256'(mem_addr_a),  256'(5'h05));
    check("wr_mem_wdata",  mem_wdata_a,       256'hA5);
    tick();
    check("wr_after_en",   256'(mem_en_a),    256'(0));
    check("wr_after_we",   256'(mem_we_a),    256'(0));
    check("wr_hold_addr",  256'(mem_addr_a),  256'(5'h05));

    // Read 0x25 from bank 1 (local 0x05)
    send_a(1'b0, 6'h25, 256'h0);
    req_valid_a = 1'b0;
    tick();
    check("rd_mem_en",     256'(mem_en_a),    256'(2'b10));
    check("rd_mem_we",     256'(mem_we_a),    256'(0));
    check("rd_mem_addr",   256'(mem_addr_a),  256'(5'h05));
    tick();
    check("rd_wait_valid", 256'(rsp_valid_a), 256'(0));
    check("rd_wait_en",    256'(mem_en_a),    256'(0));
    tick();
    check("rd_rsp_valid",  256'(rsp_valid_a), 256'(1));
    check("rd_rsp_rdata",  rsp_rdata_a,       256'hDEAD);
    tick();
    check("rd_rsp_pulse",  256'(rsp_valid_a), 256'(0));
    check("rd_rsp_hold",   rsp_rdata_a,       256'hDEAD);

    // Burst of 8 writes to addresses 0..7 with valid held throughout
    base_iss = iss_addr_q.size();
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(1'b1, 6'(i), 256'h100 + 256'(i));
    req_valid_a = 1'b0;
    check("burst_backpressure", 256'(saw_not_ready), 256'(1));
    n = 0;
    while (iss_addr_q.size() < base_iss + 8 && n < 40) begin
      tick();
      n++;
    end
    check("burst_issue_count", 256'(iss_addr_q.size() - base_iss), 256'(8));
    if (iss_addr_q.size() >= base_iss + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("burst_addr",  256'(iss_addr_q[base_iss + i]), 256'(i));
        check("burst_wdata", iss_data_q[base_iss + i], 256'h100 + 256'(i));
        check("burst_we",    256'(iss_we_q[base_iss + i]), 256'(2'b01));
        if (i > 0)
          check("burst_spacing",
                256'(iss_cyc_q[base_iss + i] - iss_cyc_q[base_iss + i - 1]), 256'(2));
      end
    end
    tick();
    tick();

    // Reset during WAIT_RD with two reads still queued
    send_a(1'b0, 6'h25, 256'h0);
    send_a(1'b0, 6'h26, 256'h0);
    send_a(1'b0, 6'h27, 256'h0);
    req_valid_a = 1'b0;
    base_iss = iss_addr_q.size();
    base_rsp = rsp_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready",     256'(req_ready_a), 256'(1));
    check("mid_rst_mem_en",    256'(mem_en_a),    256'(0));
    check("mid_rst_rsp_valid", 256'(rsp_valid_a), 256'(0));
    check("mid_rst_rsp_rdata", rsp_rdata_a,       256'(0));
    for (int i = 0; i < 12; i++) tick();
    check("mid_rst_no_rsp",   256'(rsp_cnt - base_rsp), 256'(0));
    check("mid_rst_no_issue", 256'(iss_addr_q.size() - base_iss), 256'(0));

    // Four banks, latency 3: read 0x3F -> bank 3, local 0x0F
    req_write_b = 1'b0;
    req_addr_b  = 6'h3F;
    req_valid_b = 1'b1;
    check("b_ready", 256'(req_ready_b), 256'(1));
    tick();
    req_valid_b = 1'b0;
    tick();
    check("b_mem_en",   256'(mem_en_b),   256'(4'b1000));
    check("b_mem_we",   256'(mem_we_b),   256'(0));
    check("b_mem_addr", 256'(mem_addr_b), 256'(4'hF));
    tick();
    tick();
    tick();
    check("b_rsp_early", 256'(rsp_valid_b), 256'(0));
    tick();
    check("b_rsp_valid", 256'(rsp_valid_b), 256'(1));
    check("b_rsp_rdata", rsp_rdata_b,       256'hB3B3);
    tick();
    check("b_rsp_pulse", 256'(rsp_valid_b), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
